// File: rtl/wide_comp_seq.sv
// wide_comp_seq: walks two NIBBLES*4-bit unsigned operands through one external
// 4-bit magnitude comparator, MSB nibble first, stopping on the first unequal nibble.
module wide_comp_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic [3:0]             cmp_a,
  output logic [3:0]             cmp_b,
  input  logic                   cmp_g,
  input  logic                   cmp_l,
  input  logic                   cmp_e,
  output logic                   busy,
  output logic                   done,
  output logic                   gt,
  output logic                   lt,
  output logic                   eq,
  output logic                   err
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [IW-1:0]  idx;
  logic           one_hot;

  // Comparator health: exactly one of G/L/E must be asserted
  always_comb begin
    one_hot = ({1'b0, cmp_g} + {1'b0, cmp_l} + {1'b0, cmp_e}) == 2'd1;
  end

  // Present the current nibble pair while running, zeros while idle
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    if (state == RUN) begin
      cmp_a = a_q[4*idx +: 4];
      cmp_b = b_q[4*idx +: 4];
    end
  end

  // Sequencer: accept, step through nibbles, decide, pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IW'(NIBBLES - 1);
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!one_hot) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            err   <= 1'b1;
          end else if (cmp_g) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= 1'b1;
            lt    <= 1'b0;
            eq    <= 1'b0;
            err   <= 1'b0;
          end else if (cmp_l) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= 1'b0;
            lt    <= 1'b1;
            eq    <= 1'b0;
            err   <= 1'b0;
          end else if (idx == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            err   <= 1'b0;
          end else begin
            idx <= idx - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_comp_seq.sv
// tb_wide_comp_seq: randomized and directed checks of wide_comp_seq (NIBBLES=4)
// against a whole-operand reference model, with a behavioural 4-bit comparator.
module tb_wide_comp_seq;

  localparam int unsigned N = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  cmp_a;
  logic [3:0]  cmp_b;
  logic        cmp_g;
  logic        cmp_l;
  logic        cmp_e;
  logic        busy;
  logic        done;
  logic        gt;
  logic        lt;
  logic        eq;
  logic        err;
  logic        force_fault;

  int unsigned checks;
  int unsigned failures;

  // Expected held result flags
  logic e_gt, e_lt, e_eq, e_err;

  wide_comp_seq #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cmp_a (cmp_a),
    .cmp_b (cmp_b),
    .cmp_g (cmp_g),
    .cmp_l (cmp_l),
    .cmp_e (cmp_e),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .lt    (lt),
    .eq    (eq),
    .err   (err)
  );

  // Behavioural four_bit_comp; force_fault drives G and L together
  assign cmp_g = force_fault ? 1'b1 : (cmp_a > cmp_b);
  assign cmp_l = force_fault ? 1'b1 : (cmp_a < cmp_b);
  assign cmp_e = force_fault ? 1'b0 : (cmp_a == cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Nibbles examined: the shortest MSB-aligned prefix length at which the operands differ
  function automatic int unsigned exp_m(input logic [15:0] x, input logic [15:0] y);
    for (int unsigned k = 1; k <= N; k++)
      if ((x >> (4 * (N - k))) != (y >> (4 * (N - k)))) return k;
    return N;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] x, input int unsigned i);
    logic [15:0] t;
    t = x >> (4 * i);
    return t[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One compare. *_at give the RUN cycle (1 = first cycle after accept) for a
  // disturbance, 0 = none. hold keeps start high so the next call is back-to-back.
  task automatic run_cmp(input logic [15:0] x, input logic [15:0] y, input bit hold,
                         input int unsigned poke_at, input int unsigned abort_at,
                         input int unsigned fault_at, input int unsigned rst_at);
    int unsigned m;
    int unsigned stop;
    int unsigned kind; // 0 normal, 1 fault, 2 abort, 3 reset
    m    = exp_m(x, y);
    stop = m;
    kind = 0;
    if (fault_at != 0 && fault_at <= stop) begin stop = fault_at; kind = 1; end
    if (abort_at != 0 && abort_at <= stop) begin stop = abort_at; kind = 2; end
    if (rst_at   != 0 && rst_at   <= stop) begin stop = rst_at;   kind = 3; end

    a = x; b = y; start = 1'b1;
    step();
    start = hold;
    a = 16'($urandom); b = 16'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("done_after_accept", done, 0);

    for (int unsigned k = 1; k <= stop; k++) begin
      chk("cmp_a_nibble", cmp_a, nib(x, N - k));
      chk("cmp_b_nibble", cmp_b, nib(y, N - k));
      if (k == poke_at) begin
        start = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
      end else begin
        start = hold;
      end
      abort       = (k == abort_at);
      force_fault = (k == fault_at);
      rst_n       = !(k == rst_at);
      step();
      abort = 1'b0; force_fault = 1'b0; rst_n = 1'b1; start = hold;
      if (k < stop) begin
        chk("done_early", done, 0);
        chk("busy_running", busy, 1);
      end
    end

    case (kind)
      0: begin
        e_gt = (x > y); e_lt = (x < y); e_eq = (x == y); e_err = 1'b0;
        chk("done_pulse", done, 1);
      end
      1: begin
        e_gt = 1'b0; e_lt = 1'b0; e_eq = 1'b0; e_err = 1'b1;
        chk("done_fault", done, 1);
      end
      2: chk("no_done_abort", done, 0);
      default: begin
        e_gt = 1'b0; e_lt = 1'b0; e_eq = 1'b0; e_err = 1'b0;
        chk("no_done_reset", done, 0);
        chk("cmp_a_reset", cmp_a, 0);
        chk("cmp_b_reset", cmp_b, 0);
      end
    endcase
    chk("busy_end", busy, 0);
    chk("gt", gt, e_gt);
    chk("lt", lt, e_lt);
    chk("eq", eq, e_eq);
    chk("err", err, e_err);
    if (!hold) begin
      step();
      chk("done_one_cycle", done, 0);
      chk("busy_idle", busy, 0);
      chk("cmp_a_idle", cmp_a, 0);
      chk("gt_held", gt, e_gt);
      chk("eq_held", eq, e_eq);
    end
  endtask

  initial begin
    logic [15:0] x, y, mask;
    int unsigned kn, m, ab;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; force_fault = 1'b0;
    a = '0; b = '0;
    e_gt = 1'b0; e_lt = 1'b0; e_eq = 1'b0; e_err = 1'b0;

    step();
    start = 1'b1; a = 16'h1234; b = 16'h4321;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {gt, lt, eq, err}, 0);
    chk("rst_cmp", {cmp_a, cmp_b}, 0);
    start = 1'b0; rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Top nibble decides
    run_cmp(16'h8000, 16'h7FFF, 0, 0, 0, 0, 0);
    // Last nibble decides
    run_cmp(16'h1234, 16'h1235, 0, 0, 0, 0, 0);
    // Equal operands, back-to-back with start held
    run_cmp(16'hABCD, 16'hABCD, 1, 0, 0, 0, 0);
    run_cmp(16'hABCD, 16'hABCD, 1, 0, 0, 0, 0);
    run_cmp(16'h00F0, 16'h0F00, 0, 0, 0, 0, 0);
    // Start while busy is ignored
    run_cmp(16'h0001, 16'h0000, 0, 2, 0, 0, 0);
    // Abort keeps previous flags
    run_cmp(16'h5555, 16'h5556, 0, 0, 2, 0, 0);
    // Comparator fault
    run_cmp(16'h1111, 16'h1111, 0, 0, 0, 2, 0);
    run_cmp(16'h9000, 16'h1000, 0, 0, 0, 1, 0);
    // Reset mid-compare, then normal operation
    run_cmp(16'h4444, 16'h4444, 0, 0, 0, 0, 3);
    run_cmp(16'h8000, 16'h7FFF, 0, 0, 0, 0, 0);

    // Random operands sharing a random number of leading nibbles
    for (int unsigned it = 0; it < 60; it++) begin
      x    = 16'($urandom);
      kn   = $urandom_range(0, N);
      mask = (kn == N) ? 16'hFFFF : 16'((32'd1 << (4 * kn)) - 1);
      y    = x ^ (16'($urandom) & mask);
      m    = exp_m(x, y);
      ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, m) : 0;
      run_cmp(x, y, ($urandom_range(0, 3) == 0), 0, ab, 0, 0);
    end
    start = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
